dual_port_ram_cfg: RTL and testbench

Parametrised true dual-port synchronous RAM that succeeds the fixed 8x64 dual-port RAM. Width, depth, write-collision priority and read-during-write mode are all configurable. It adds a post-reset hardware clear sequencer and write-collision detection with a saturating event counter. Two independent masters share one clock and use it as a scratch or mailbox memory.

---
 rtl/dpram_pkg.sv | 16 +
 rtl/dpram_clear_seq.sv | 47 ++++
 rtl/dual_port_ram_cfg.sv | 92 +++++++++
 tb/tb_dual_port_ram_cfg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and types for the configurable dual-port RAM.
// Read-during-write modes, collision priority and clear FSM states.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int PRIO_B = 0;
  localparam int PRIO_A = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then parks in RUN.
// init_busy falls on the edge that performs the final clear write.
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  assign clr_we   = (state == INIT);
  assign clr_addr = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      unique case (state)
        INIT: begin
          ptr <= ptr + ADDR_W'(1);
          if (&ptr) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
          state     <= RUN;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= INIT;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_port_ram_cfg.sv
// True dual-port synchronous RAM with hardware clear after reset
// and write-write collision detection with a saturating counter.
module dual_port_ram_cfg
  import dpram_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 6,
  parameter int                RDW_MODE   = 0,
  parameter int                PRIORITY_A = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
  parameter int                CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              init_busy,
  output logic              collision,
  output logic [CNT_W-1:0]  collision_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              hit;
  logic              wa;
  logic              wb;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  dpram_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_busy(init_busy)
  );

  assign run = ~init_busy;
  assign hit = run & we_a & we_b & (addr_a == addr_b);

  // On a collision only the priority port's write reaches the array
  assign wa = run & we_a & ~(hit & (PRIORITY_A == PRIO_B));
  assign wb = run & we_b & ~(hit & (PRIORITY_A == PRIO_A));

  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= CLEAR_VAL;
    if (wa)     mem[addr_a]   <= data_a;
    if (wb)     mem[addr_b]   <= data_b;
  end

  always_comb begin
    rd_a = mem[addr_a];
    rd_b = mem[addr_b];
    if (RDW_MODE != RDW_READ_FIRST) begin
      if (we_a) rd_a = data_a;
      if (we_b) rd_b = data_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a           <= '0;
      q_b           <= '0;
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else if (init_busy) begin
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else begin
      q_a       <= rd_a;
      q_b       <= rd_b;
      collision <= hit;
      if (hit && (collision_cnt != '1))
        collision_cnt <= collision_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_port_ram_cfg.sv
// Bench for dual_port_ram_cfg: three configurations in lockstep,
// checked every cycle against an array model plus literal spot checks.
module tb_dual_port_ram_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_a, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [15:0] da, db;

  logic [7:0]  q_a0, q_b0, q_a1, q_b1;
  logic [15:0] q_a2, q_b2;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic        busy0, busy1, busy2;
  logic        col0, col1, col2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dual_port_ram_cfg #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0),
    .PRIORITY_A(1), .CNT_W(8)) d0 (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .addr_a(addr_a), .data_a(da[7:0]), .q_a(q_a0),
    .we_b(we_b), .addr_b(addr_b), .data_b(db[7:0]), .q_b(q_b0),
    .init_busy(busy0), .collision(col0), .collision_cnt(cnt0));

  dual_port_ram_cfg #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1),
    .PRIORITY_A(0), .CNT_W(8)) d1 (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .addr_a(addr_a), .data_a(da[7:0]), .q_a(q_a1),
    .we_b(we_b), .addr_b(addr_b), .data_b(db[7:0]), .q_b(q_b1),
    .init_busy(busy1), .collision(col1), .collision_cnt(cnt1));

  dual_port_ram_cfg #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0),
    .PRIORITY_A(1), .CNT_W(8)) d2 (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .addr_a(addr_a[3:0]), .data_a(da), .q_a(q_a2),
    .we_b(we_b), .addr_b(addr_b[3:0]), .data_b(db), .q_b(q_b2),
    .init_busy(busy2), .collision(col2), .collision_cnt(cnt2));

  function automatic int dep(int k);
    return (k == 2) ? 16 : 64;
  endfunction
  function automatic int msk(int k);
    return (k == 2) ? 16'hFFFF : 8'hFF;
  endfunction
  function automatic bit wfirst(int k);
    return k == 1;
  endfunction
  function automatic bit prio_a(int k);
    return k != 1;
  endfunction

  // model state per instance
  int mm [3][64];
  int eqa [3] = '{0, 0, 0};
  int eqb [3] = '{0, 0, 0};
  int ecol [3] = '{0, 0, 0};
  int ecnt [3] = '{0, 0, 0};
  int left [3] = '{64, 64, 16};

  task automatic model_edge(input int k);
    int a, b, x, y, ra, rb;
    bit c;
    a = int'(addr_a) % dep(k);
    b = int'(addr_b) % dep(k);
    x = int'(da) & msk(k);
    y = int'(db) & msk(k);
    if (left[k] > 0) begin
      left[k]--;
      if (left[k] == 0)
        for (int i = 0; i < 64; i++) mm[k][i] = 0;
      eqa[k] = 0;
      eqb[k] = 0;
      ecol[k] = 0;
    end else begin
      ra = (we_a && wfirst(k)) ? x : mm[k][a];
      rb = (we_b && wfirst(k)) ? y : mm[k][b];
      c = we_a && we_b && (a == b);
      if (c) mm[k][a] = prio_a(k) ? x : y;
      else begin
        if (we_a) mm[k][a] = x;
        if (we_b) mm[k][b] = y;
      end
      eqa[k] = ra;
      eqb[k] = rb;
      ecol[k] = c ? 1 : 0;
      if (c && ecnt[k] < 255) ecnt[k]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        left[k] = dep(k);
        eqa[k] = 0;
        eqb[k] = 0;
        ecol[k] = 0;
        ecnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) model_edge(k);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  int aqa [3], aqb [3], acnt [3], abusy [3], acol [3];
  always_comb begin
    aqa[0] = int'(q_a0); aqa[1] = int'(q_a1); aqa[2] = int'(q_a2);
    aqb[0] = int'(q_b0); aqb[1] = int'(q_b1); aqb[2] = int'(q_b2);
    acnt[0] = int'(cnt0); acnt[1] = int'(cnt1); acnt[2] = int'(cnt2);
    abusy[0] = int'(busy0); abusy[1] = int'(busy1); abusy[2] = int'(busy2);
    acol[0] = int'(col0); acol[1] = int'(col1); acol[2] = int'(col2);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("q_a%0d", k), aqa[k], eqa[k]);
      chk($sformatf("q_b%0d", k), aqb[k], eqb[k]);
      chk($sformatf("busy%0d", k), abusy[k], (left[k] > 0) ? 1 : 0);
      chk($sformatf("col%0d", k), acol[k], ecol[k]);
      chk($sformatf("cnt%0d", k), acnt[k], ecnt[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic dual(input int a, input int x, input int b, input int y);
    we_a = 1'b1; addr_a = 6'(a); da = 16'(x);
    we_b = 1'b1; addr_b = 6'(b); db = 16'(y);
    step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    addr_a = '0; addr_b = '0; da = '0; db = '0;
    repeat (3) step();
    chk("rst_busy", int'(busy0), 1);
    chk("rst_q_a", int'(q_a0), 0);
    rst_n = 1'b1;
    // write attempt while clearing must be dropped
    we_a = 1'b1; addr_a = 6'd5; da = 16'h0011;
    step();
    idle();
    repeat (14) step();
    chk("d2_busy_15", int'(busy2), 1);
    step();
    chk("d2_busy_16", int'(busy2), 0);
    repeat (47) step();
    chk("d0_busy_63", int'(busy0), 1);
    step();
    chk("d0_busy_64", int'(busy0), 0);
    addr_a = 6'd0; step(); chk("clr0", int'(q_a0), 0);
    addr_a = 6'd37; step(); chk("clr37", int'(q_a0), 0);
    addr_a = 6'd63; step(); chk("clr63", int'(q_a0), 0);
    addr_a = 6'd5; step(); chk("init_wr5", int'(q_a0), 0);

    we_a = 1'b1; addr_a = 6'd10; da = 16'h00AA; step(); idle();
    step(); chk("rd_a10", int'(q_a0), 8'hAA);
    we_b = 1'b1; addr_b = 6'd20; db = 16'h0055; step(); idle();
    step(); chk("rd_b20", int'(q_b0), 8'h55);

    dual(15, 8'hF0, 15, 8'h0F);
    chk("col_pulse", int'(col0), 1);
    chk("col_cnt1", int'(cnt0), 1);
    chk("wf_lose_a", int'(q_a1), 8'hF0);
    addr_a = 6'd15; addr_b = 6'd15; step();
    chk("col_gone", int'(col0), 0);
    chk("prio_a", int'(q_a0), 8'hF0);
    chk("prio_b", int'(q_b1), 8'h0F);

    we_a = 1'b1; addr_a = 6'd7; da = 16'h0033; step();
    da = 16'h0044; addr_b = 6'd7; step(); idle();
    chk("rdw_rf", int'(q_a0), 8'h33);
    chk("rdw_wf", int'(q_a1), 8'h44);
    chk("cross0", int'(q_b0), 8'h33);
    chk("cross1", int'(q_b1), 8'h33);

    dual(3, 16'hBEEF, 12, 16'h1234);
    chk("d2_nocol", int'(col2), 0);
    addr_a = 6'd3; addr_b = 6'd12; step();
    chk("d2_rd3", int'(q_a2), 16'hBEEF);
    chk("d2_rd12", int'(q_b2), 16'h1234);

    dual(40, 1, 40, 2);
    dual(41, 3, 41, 4);
    chk("cnt3", int'(cnt0), 3);
    rst_n = 1'b0;
    #1;
    chk("arst_q", int'(q_a0), 0);
    chk("arst_busy", int'(busy0), 1);
    chk("arst_cnt", int'(cnt0), 0);
    step();
    rst_n = 1'b1;
    repeat (64) step();
    addr_a = 6'd10; step();
    chk("post_rst10", int'(q_a0), 0);
    chk("post_cnt", int'(cnt0), 0);

    for (int i = 0; i < 300; i++) dual(i % 64, i, i % 64, i + 1);
    step();
    chk("sat0", int'(cnt0), 255);
    chk("sat2", int'(cnt2), 255);
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
